// File: rtl/game_pkg.sv
// Shared types and key constants for the keyboard front end.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } key_state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  function automatic logic is_key(input logic [7:0] code);
    return code != KEY_NONE;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the 8-bit raw scan code; only the second flop is used downstream.
module key_sync
  import game_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] meta_q, meta_d;
  logic [7:0] sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_q <= KEY_NONE;
      sync_q <= KEY_NONE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/key_event_filter.sv
// Debounces a raw keyboard scan code and emits press/release pulses.
// Define KEY_REPEAT_EN to add the auto-repeat state, its delay/period counters and repeat pulses.
module key_event_filter
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_raw,
  output logic [7:0] key_code,
  output logic       key_press,
  output logic       key_release,
  output logic       key_held
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

  logic [7:0]      sync;
  logic [7:0]      cand_q, cand_d;
  logic [DB_W-1:0] match_q, match_d;
  logic [7:0]      stable_q, stable_d;
  key_state_t      state_q, state_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            held_q, held_d;
  logic            accept;

`ifdef KEY_REPEAT_EN
  localparam int unsigned DLY_W = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned PER_W = $clog2(REPEAT_PERIOD + 1);
  localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(REPEAT_DELAY);
  localparam logic [PER_W-1:0] PER_MAX = PER_W'(REPEAT_PERIOD);

  logic [DLY_W-1:0] delay_q, delay_d;
  logic [PER_W-1:0] period_q, period_d;
`else
  // Repeat timing has no effect in this build.
  if (REPEAT_DELAY != 0 || REPEAT_PERIOD != 0) begin : g_repeat_params_ignored
  end
`endif

  key_sync u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .din   (keycode_raw),
    .dout  (sync)
  );

  // Acceptance fires only on the cycle the match count first reaches its limit.
  always_comb begin
    cand_d  = cand_q;
    match_d = match_q;
    accept  = 1'b0;
    if (sync != cand_q) begin
      cand_d  = sync;
      match_d = '0;
    end else if (match_q != DB_MAX) begin
      match_d = match_q + 1'b1;
      accept  = (match_d == DB_MAX) && (cand_q != stable_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    stable_d  = stable_q;
`ifdef KEY_REPEAT_EN
    delay_d  = delay_q;
    period_d = period_q;
`endif
    if (accept) begin
      stable_d  = cand_q;
      state_d   = is_key(cand_q) ? HELD : IDLE;
      press_d   = is_key(cand_q);
      release_d = !is_key(cand_q);
`ifdef KEY_REPEAT_EN
      delay_d  = '0;
      period_d = '0;
`endif
    end else begin
      case (state_q)
        HELD: begin
`ifdef KEY_REPEAT_EN
          if (delay_q == DLY_MAX - 1'b1) begin
            delay_d  = DLY_MAX;
            period_d = '0;
            press_d  = 1'b1;
            state_d  = REPEAT;
          end else if (delay_q != DLY_MAX) begin
            delay_d = delay_q + 1'b1;
          end
`endif
        end
        REPEAT: begin
`ifdef KEY_REPEAT_EN
          if (period_q == PER_MAX - 1'b1) begin
            period_d = '0;
            press_d  = 1'b1;
          end else begin
            period_d = period_q + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
    held_d = is_key(stable_d);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cand_q    <= KEY_NONE;
      match_q   <= '0;
      stable_q  <= KEY_NONE;
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
      delay_q  <= '0;
      period_q <= '0;
`endif
    end else begin
      cand_q    <= cand_d;
      match_q   <= match_d;
      stable_q  <= stable_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      held_q    <= held_d;
`ifdef KEY_REPEAT_EN
      delay_q  <= delay_d;
      period_q <= period_d;
`endif
    end
  end

  assign key_code    = stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_held    = held_q;

endmodule

// File: tb/tb_key_event_filter.sv
// Self-checking bench for key_event_filter: vector table, timed corner sequences and random stimulus
// compared every cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_key_event_filter;
  import game_pkg::*;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode_raw = 8'h00;
  logic [7:0] key_code;
  logic       key_press, key_release, key_held;

  key_event_filter #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .keycode_raw (keycode_raw),
    .key_code    (key_code),
    .key_press   (key_press),
    .key_release (key_release),
    .key_held    (key_held)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a code is accepted once the filter has seen it D+1 samples in a row
  // (samples reach the filter two clocks late); repeats follow from time since acceptance.
  logic [7:0] m_pipe0 = 8'h00, m_pipe1 = 8'h00, m_run_val = 8'h00, m_code = 8'h00;
  int         m_run_len = 1;
  int         m_elapsed = 0;
  logic       m_press = 1'b0, m_release = 1'b0;
  logic       model_valid = 1'b0;

  task automatic model_step();
    logic [7:0] seen;
    if (Reset) begin
      m_pipe0 = 8'h00; m_pipe1 = 8'h00; m_run_val = 8'h00; m_run_len = 1;
      m_code = 8'h00; m_press = 1'b0; m_release = 1'b0; m_elapsed = 0;
      model_valid = 1'b1;
    end else begin
      seen = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = keycode_raw;
      if (seen == m_run_val) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_val = seen;
        m_run_len = 1;
      end
      m_press = 1'b0;
      m_release = 1'b0;
      if (m_run_len >= DB + 1 && m_run_val != m_code) begin
        m_press   = (m_run_val != 8'h00);
        m_release = (m_run_val == 8'h00);
        m_code    = m_run_val;
        m_elapsed = 0;
      end else if (m_code != 8'h00) begin
        m_elapsed++;
`ifdef KEY_REPEAT_EN
        if (m_elapsed >= RD && ((m_elapsed - RD) % RP) == 0) m_press = 1'b1;
`endif
      end
    end
  endtask

  always @(posedge Clk) model_step();

  always @(negedge Clk) begin
    if (model_valid) begin
      check_output("sb key_code", int'(key_code), int'(m_code));
      check_output("sb key_press", int'(key_press), int'(m_press));
      check_output("sb key_release", int'(key_release), int'(m_release));
      check_output("sb key_held", int'(key_held), int'(m_code != 8'h00));
      check_output("sb press_and_release", int'(key_press & key_release), 0);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] raw, input int hold,
                                output int presses, output int releases);
    keycode_raw = raw;
    presses = 0;
    releases = 0;
    repeat (hold) begin
      step();
      presses  += int'(key_press);
      releases += int'(key_release);
    end
  endtask

  typedef struct {
    logic [7:0] raw;
    int         hold;
    int         presses;
    int         releases;
    logic [7:0] code;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int   p, r;
    int   found;
    int   got_off[$];
    int   exp_off[$];
    logic [7:0] pool[5];

    vecs[0] = '{8'h00, 12, 0, 1, 8'h00};
    vecs[1] = '{KEY_ENTER, 3, 0, 0, 8'h00};
    vecs[2] = '{8'h00, 12, 0, 0, 8'h00};
    vecs[3] = '{8'h04, 12, 1, 0, 8'h04};
    vecs[4] = '{8'h05, 12, 1, 0, 8'h05};
    vecs[5] = '{8'h00, 12, 0, 1, 8'h00};
    vecs[6] = '{8'h1A, 10, 1, 0, 8'h1A};
    vecs[7] = '{KEY_ENTER, 2, 0, 0, 8'h1A};
    vecs[8] = '{8'h1A, 6, 0, 0, 8'h1A};
    vecs[9] = '{8'h00, 12, 0, 1, 8'h00};

    // Reset held for edges 1..3; outputs checked while still in reset.
    Reset = 1'b1;
    keycode_raw = 8'h00;
    repeat (2) step();
    check_output("reset key_code", int'(key_code), 0);
    check_output("reset key_press", int'(key_press), 0);
    check_output("reset key_release", int'(key_release), 0);
    check_output("reset key_held", int'(key_held), 0);
    step();
    Reset = 1'b0;

    // Enter driven from edge 10 must be accepted exactly at edge 17.
    repeat (7) step();
    keycode_raw = KEY_ENTER;
    repeat (6) step();
    check_output("latency early press", int'(key_press), 0);
    step();
    check_output("latency press", int'(key_press), 1);
    check_output("latency key_code", int'(key_code), int'(KEY_ENTER));
    check_output("latency key_held", int'(key_held), 1);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].raw, vecs[i].hold, p, r);
      check_output($sformatf("vec%0d presses", i), p, vecs[i].presses);
      check_output($sformatf("vec%0d releases", i), r, vecs[i].releases);
      check_output($sformatf("vec%0d key_code", i), int'(key_code), int'(vecs[i].code));
    end

    // One-cycle reset while Enter is held: silent clear, then a fresh press 7 edges later.
    apply_stimulus(KEY_ENTER, 12, p, r);
    check_output("pre-reset press", p, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_output("in-reset key_code", int'(key_code), 0);
    check_output("in-reset key_held", int'(key_held), 0);
    check_output("in-reset key_release", int'(key_release), 0);
    check_output("in-reset key_press", int'(key_press), 0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check_output($sformatf("post-reset release e%0d", k), int'(key_release), 0);
      check_output($sformatf("post-reset press e%0d", k), int'(key_press), int'(k == 7));
    end
    check_output("post-reset key_code", int'(key_code), int'(KEY_ENTER));

    // Release timing.
    keycode_raw = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_output($sformatf("release pulse e%0d", k), int'(key_release), int'(k == 7));
    end
    check_output("release key_held", int'(key_held), 0);
    check_output("release key_code", int'(key_code), 0);

    // Long hold: find acceptance, then record press offsets over the following 59 cycles.
    keycode_raw = 8'h1A;
    found = 0;
    for (int k = 1; k <= 12 && found == 0; k++) begin
      step();
      if (key_press) found = 1;
    end
    check_output("hold acceptance seen", found, 1);
    for (int off = 1; off < 60; off++) begin
      step();
      if (key_press) got_off.push_back(off);
    end
`ifdef KEY_REPEAT_EN
    exp_off = '{20, 28, 36, 44, 52};
`endif
    check_output("repeat count", got_off.size(), exp_off.size());
    for (int i = 0; i < exp_off.size(); i++)
      check_output($sformatf("repeat offset %0d", i), (i < got_off.size()) ? got_off[i] : -1, exp_off[i]);
    apply_stimulus(8'h00, 12, p, r);
    check_output("hold release", r, 1);

    // Random bursts, judged by the reference model each cycle.
    pool = '{8'h00, 8'h04, 8'h05, 8'h1A, KEY_ENTER};
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 11) == 0) begin
        Reset = 1'b1;
        step();
        Reset = 1'b0;
      end
      apply_stimulus(pool[$urandom_range(0, 4)], int'($urandom_range(1, 10)), p, r);
    end
    apply_stimulus(8'h00, 12, p, r);
    check_output("final key_code", int'(key_code), 0);

    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
